// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment display blocks.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bit positions inside the {a,b,c,d,e,f,g,dp} segment byte
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Application-side and pin-side signals of the display scan controller.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                      enable;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     AN;
  logic [7:0]                Salida;
  logic                      frame_done;

  modport master (
    output enable, load, digits_in, dp_mask, blank_mask,
    input  AN, Salida, frame_done
  );

  modport slave (
    input  enable, load, digits_in, dp_mask, blank_mask,
    output AN, Salida, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl_seg_hex_decoder.sv
// Hex nibble to active-low {a,b,c,d,e,f,g} segment pattern.
module seg_hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with blanking guard and
// frame-synchronous double-buffered display contents.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst,
  display_scan_ctrl_if.slave bus
);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = $clog2(REFRESH_DIV);

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [PRESC_W-1:0]      presc;

  logic [4*NUM_DIGITS-1:0] active_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   active_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   active_blank, pend_blank;
  logic                    pend_flag;

  logic [NUM_DIGITS-1:0]   an_p1;
  logic [7:0]              salida_p1;
  logic                    frame_done_p1;

  logic                    slot_end, last_slot_end, boundary, show_lit;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;
  logic [7:0]              salida_nxt;

  assign slot_end      = (state == SHOW) && (presc == PRESC_W'(REFRESH_DIV - 1));
  assign last_slot_end = bus.enable && slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  // Leaving IDLE also starts a fresh frame, so pending data may be adopted there
  assign boundary      = last_slot_end || (bus.enable && (state == IDLE));
  assign show_lit      = bus.enable && (state == SHOW) && !active_blank[idx];
  assign cur_nibble    = active_digits[{idx, 2'b00} +: 4];

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    salida_nxt               = SEG_OFF;
    salida_nxt[SEG_A:SEG_G]  = cur_seg;
    salida_nxt[SEG_DP]       = ~active_dp[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      presc         <= '0;
      active_digits <= '0;
      active_dp     <= '0;
      active_blank  <= '0;
      pend_digits   <= '0;
      pend_dp       <= '0;
      pend_blank    <= '0;
      pend_flag     <= 1'b0;
      an_p1         <= '1;
      salida_p1     <= SEG_OFF;
      frame_done_p1 <= 1'b0;
    end else begin
      // Output stage: registered view of the current FSM state
      an_p1         <= show_lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      salida_p1     <= show_lit ? salida_nxt : SEG_OFF;
      frame_done_p1 <= last_slot_end;

      if (bus.load) begin
        pend_digits <= bus.digits_in;
        pend_dp     <= bus.dp_mask;
        pend_blank  <= bus.blank_mask;
      end
      if (boundary && bus.load) begin
        active_digits <= bus.digits_in;
        active_dp     <= bus.dp_mask;
        active_blank  <= bus.blank_mask;
        pend_flag     <= 1'b0;
      end else if (boundary && pend_flag) begin
        active_digits <= pend_digits;
        active_dp     <= pend_dp;
        active_blank  <= pend_blank;
        pend_flag     <= 1'b0;
      end else if (bus.load) begin
        pend_flag     <= 1'b1;
      end

      if (!bus.enable) begin
        state <= IDLE;
        idx   <= '0;
        presc <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            idx   <= '0;
            presc <= '0;
          end
          BLANK: begin
            presc <= presc + 1'b1;
            if (presc == PRESC_W'(BLANK_CYCLES - 1)) state <= SHOW;
          end
          SHOW: begin
            if (slot_end) begin
              presc <= '0;
              state <= BLANK;
              idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            idx   <= '0;
            presc <= '0;
          end
        endcase
      end
    end
  end

  assign bus.AN         = an_p1;
  assign bus.Salida     = salida_p1;
  assign bus.frame_done = frame_done_p1;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS   (8),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int n     = 0;
  logic [6:0] glyph [16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic dark(input string tag);
    tick;
    chk8({tag, " AN"}, bus.AN, 8'hFF);
    chk8({tag, " Salida"}, bus.Salida, 8'hFF);
    chk1({tag, " frame_done"}, bus.frame_done, 1'b0);
  endtask

  // One clock of an uninterrupted scan; n counts edges since the IDLE exit edge
  task automatic step(input logic [31:0] dig, input logic [7:0] dpm, input logic [7:0] blm);
    int s, k;
    logic [7:0] ean, esal;
    logic efd;
    tick;
    n++;
    s = (n - 1) % 32;
    k = s / 4;
    if ((s % 4 == 0) || blm[k]) begin
      ean  = 8'hFF;
      esal = 8'hFF;
    end else begin
      ean  = ~(8'h01 << k);
      esal = {glyph[dig[4*k +: 4]], ~dpm[k]};
    end
    efd = (n % 32 == 0);
    chk8($sformatf("AN n=%0d", n), bus.AN, ean);
    chk8($sformatf("Salida n=%0d", n), bus.Salida, esal);
    chk1($sformatf("frame_done n=%0d", n), bus.frame_done, efd);
  endtask

  task automatic run(input int cnt, input logic [31:0] dig, input logic [7:0] dpm,
                     input logic [7:0] blm);
    for (int i = 0; i < cnt; i++) step(dig, dpm, blm);
  endtask

  initial begin
    glyph = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.digits_in  = '0;
    bus.dp_mask    = '0;
    bus.blank_mask = '0;

    // 1: reset, display dark
    dark("reset0");
    dark("reset1");
    dark("reset2");
    chk1("digit0 slot starts dark", bus.AN[0], 1'b1);

    // 2: scan order, load coincident with leaving IDLE
    rst           = 1'b0;
    bus.load      = 1'b1;
    bus.digits_in = 32'h8765_4321;
    bus.enable    = 1'b1;
    dark("idle_exit");
    bus.load = 1'b0;
    n = 0;
    step(32'h8765_4321, 8'h00, 8'h00);
    step(32'h8765_4321, 8'h00, 8'h00);
    chk8("digit0 glyph", bus.Salida, 8'b1001_1111);
    run(62, 32'h8765_4321, 8'h00, 8'h00);

    // 3: mid-frame load is deferred to the next frame
    run(10, 32'h8765_4321, 8'h00, 8'h00);
    bus.load      = 1'b1;
    bus.digits_in = 32'hFFFF_FFFF;
    run(1, 32'h8765_4321, 8'h00, 8'h00);
    bus.load = 1'b0;
    run(21, 32'h8765_4321, 8'h00, 8'h00);
    run(2, 32'hFFFF_FFFF, 8'h00, 8'h00);
    chk8("all-F glyph", bus.Salida, 8'b0111_0001);
    run(30, 32'hFFFF_FFFF, 8'h00, 8'h00);

    // 4: load on the frame-boundary cycle takes effect immediately
    run(31, 32'hFFFF_FFFF, 8'h00, 8'h00);
    bus.load      = 1'b1;
    bus.digits_in = 32'h1357_9BDF;
    run(1, 32'hFFFF_FFFF, 8'h00, 8'h00);
    bus.load = 1'b0;
    run(32, 32'h1357_9BDF, 8'h00, 8'h00);

    // 5: masks, with the last of two loads in a frame winning
    run(5, 32'h1357_9BDF, 8'h00, 8'h00);
    bus.load      = 1'b1;
    bus.digits_in = 32'hDEAD_BEEF;
    run(1, 32'h1357_9BDF, 8'h00, 8'h00);
    bus.load = 1'b0;
    run(9, 32'h1357_9BDF, 8'h00, 8'h00);
    bus.load       = 1'b1;
    bus.digits_in  = 32'h2468_ACE0;
    bus.blank_mask = 8'h04;
    bus.dp_mask    = 8'h01;
    run(1, 32'h1357_9BDF, 8'h00, 8'h00);
    bus.load       = 1'b0;
    bus.blank_mask = 8'h00;
    bus.dp_mask    = 8'h00;
    run(16, 32'h1357_9BDF, 8'h00, 8'h00);
    run(2, 32'h2468_ACE0, 8'h01, 8'h04);
    chk8("digit0 with dp", bus.Salida, 8'b0000_0010);
    run(30, 32'h2468_ACE0, 8'h01, 8'h04);

    // 6a: enable dropped during digit 5, then restart from digit 0
    run(22, 32'h2468_ACE0, 8'h01, 8'h04);
    chk8("digit5 showing", bus.AN, 8'hDF);
    bus.enable = 1'b0;
    dark("disable0");
    dark("disable1");
    dark("disable2");
    bus.enable = 1'b1;
    dark("reenable");
    n = 0;
    run(32, 32'h2468_ACE0, 8'h01, 8'h04);

    // 6b: reset during digit 5 clears the buffers
    run(22, 32'h2468_ACE0, 8'h01, 8'h04);
    rst = 1'b1;
    dark("midrst0");
    dark("midrst1");
    rst = 1'b0;
    dark("post_rst");
    n = 0;
    run(32, 32'h0000_0000, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
